handshake_load_responder: RTL and testbench

- Memory-side end of the handshake load protocol. Accepts load addresses on the memory-address channel and reads a synchronous SRAM. Returns read data in order on the memory-data channel.
- Sits between the compute-side load adapters and an SRAM macro or array.
- Buffers responses in an internal FIFO so that backpressure on the data channel never drops or reorders a read.

---
 rtl/handshake_pkg.sv | 18 +
 rtl/handshake_sync_fifo.sv | 63 ++++++
 rtl/handshake_load_responder.sv | 128 ++++++++++++
 tb/tb_handshake_load_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake load responder and its response FIFO.
// Optional build macro used by the responder: HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN.
package handshake_pkg;

  // Ceiling log2 that never returns 0. A one-entry structure still gets a
  // one-bit pointer, so no zero-width vector is ever declared.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/handshake_sync_fifo.sv
// Synchronous response FIFO with separate occupancy counter.
// Pointers are log2(DEPTH) bits and wrap naturally (DEPTH is a power of two).
// Push and pop in the same cycle are legal at any occupancy, including full.
module handshake_sync_fifo
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [clog2_min1(DEPTH):0] count,
  output logic                       empty
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff;

  // A pop against an empty FIFO is ignored so the counter can never underflow.
  assign pop_eff = pop && (count_q != '0);

  // Next-state pointers and count; simultaneous push/pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop_eff);
    count_d  = count_q + CW'(push) - CW'(pop_eff);
  end

  // Pointer and counter registers, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the counter qualifies them.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/handshake_load_responder.sv
// Memory-side end of the handshake load protocol: accepts word addresses,
// reads a synchronous SRAM (1-cycle read latency) and returns data in order.
// A credit scheme (FIFO count + read in flight) guarantees every issued read
// has a FIFO slot waiting for it, so backpressure never drops or reorders data.
// Optional macro HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN adds mem_data_err and
// turns reads at or above MEM_DEPTH into error responses without an SRAM read.
module handshake_load_responder
  import handshake_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_addr_valid,
  output logic                  mem_addr_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr_data,
  output logic                  mem_data_valid,
  input  logic                  mem_data_ready,
  output logic [DATA_WIDTH-1:0] mem_data,
`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
  output logic                  mem_data_err,
`endif
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CW = clog2_min1(RESP_DEPTH) + 1;

  typedef struct packed {
`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
    logic                  err;
`endif
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  localparam int RW = $bits(resp_t);

  logic          accept;
  logic          pop;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ;
  logic          fifo_empty;
  resp_t         push_entry;
  resp_t         head_entry;

  // Credits: entries already buffered plus the read whose data lands next edge.
  // mem_addr_ready depends on registered state and rst_n only, never on
  // mem_data_ready or mem_addr_valid.
  assign occ            = fifo_count + CW'(inflight_q);
  assign mem_addr_ready = rst_n && (occ < CW'(RESP_DEPTH));
  assign accept         = mem_addr_valid && mem_addr_ready;

  assign mem_data_valid = rst_n && !fifo_empty;
  assign pop            = mem_data_valid && mem_data_ready;

  assign sram_addr = mem_addr_data;

`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic addr_oob;
  logic inflight_oob_q, inflight_oob_d;

  // Out-of-range accepts still take a credit but never touch the SRAM.
  assign addr_oob       = ({1'b0, mem_addr_data} >= MEM_LIMIT);
  assign sram_re        = accept && !addr_oob;
  assign inflight_oob_d = accept && addr_oob;

  // Remembers that the slot in flight is an error response, not SRAM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_oob_q <= 1'b0;
    end else begin
      inflight_oob_q <= inflight_oob_d;
    end
  end

  // Error entries carry zero data so stale SRAM output never leaks out.
  always_comb begin
    push_entry      = '0;
    push_entry.data = inflight_oob_q ? '0 : sram_rdata;
    push_entry.err  = inflight_oob_q;
  end

  assign mem_data_err = head_entry.err;
`else
  assign sram_re = accept;

  // Every slot in flight is a real SRAM read.
  always_comb begin
    push_entry      = '0;
    push_entry.data = sram_rdata;
  end
`endif

  assign inflight_d = accept;

  // One-deep read pipeline: the accepted read's data is valid next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  handshake_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign mem_data = head_entry.data;

endmodule

// File: tb/tb_handshake_load_responder.sv
// Directed testbench for handshake_load_responder with a behavioural SRAM
// and an in-order response scoreboard.
// Build with HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN to also exercise the bounds check.
module tb_handshake_load_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MD = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_addr_valid;
  logic          mem_addr_ready;
  logic [AW-1:0] mem_addr_data;
  logic          mem_data_valid;
  logic          mem_data_ready;
  logic [DW-1:0] mem_data;
  logic          mem_data_err;
  logic          sram_re;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          obs_err;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;
  int            n_pop = 0;
  logic          last_acc;
  logic [32:0]   exp_q[$];
  int            pop_cyc[$];
  logic [31:0]   sram [64];

  always #5 clk = ~clk;

  handshake_load_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MD),
    .RESP_DEPTH (RD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr_ready (mem_addr_ready),
    .mem_addr_data  (mem_addr_data),
    .mem_data_valid (mem_data_valid),
    .mem_data_ready (mem_data_ready),
    .mem_data       (mem_data),
`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
    .mem_data_err   (mem_data_err),
`endif
    .sram_re        (sram_re),
    .sram_addr      (sram_addr),
    .sram_rdata     (sram_rdata)
  );

`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
  assign obs_err = mem_data_err;
`else
  assign mem_data_err = 1'b0;
  assign obs_err = 1'b0;
`endif

  // Synchronous SRAM: data one cycle after sram_re, garbage otherwise.
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= sram[sram_addr[5:0]];
    else         sram_rdata <= $urandom;
  end

  function automatic logic in_range(input logic [31:0] a);
`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
    return a < MD;
`else
    return 1'b1;
`endif
  endfunction

  // Expected {err, data} for an accepted address.
  function automatic logic [32:0] model_resp(input logic [31:0] a);
    if (!in_range(a)) return {1'b1, 32'h0};
    return {1'b0, sram[a[5:0]]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, score them, then step past the edge.
  task automatic tick();
    logic        acc;
    logic        pp;
    logic [32:0] e;
    @(negedge clk);
    acc = mem_addr_valid && mem_addr_ready;
    pp  = mem_data_valid && mem_data_ready;
    last_acc = acc;
    if (rst_n) begin
      chk("sram_re", sram_re, acc && in_range(mem_addr_data));
      if (acc) begin
        chk("sram_addr", sram_addr, mem_addr_data);
        exp_q.push_back(model_resp(mem_addr_data));
        n_acc++;
      end
      if (pp) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", mem_data_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("resp", {obs_err, mem_data}, e);
        end
        pop_cyc.push_back(cyc);
        n_pop++;
      end
      $display("cyc %0d acc=%0b addr=%h pop=%0b data=%h err=%0b",
               cyc, acc, mem_addr_data, pp, mem_data, obs_err);
    end else begin
      chk("rst_addr_ready", mem_addr_ready, 1'b0);
      chk("rst_data_valid", mem_data_valid, 1'b0);
      chk("rst_sram_re", sram_re, 1'b0);
      exp_q.delete();
      $display("cyc %0d reset", cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    mem_addr_valid = 1'b0;
    mem_data_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    int          p0;
    int          idx;
    logic [32:0] e;

    for (int i = 0; i < 64; i++) sram[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    sram[16] = 32'hDEADBEEF;

    // Reset with a valid address offered: nothing may be accepted or read.
    rst_n = 1'b0;
    mem_addr_valid = 1'b1;
    mem_addr_data = 32'd7;
    mem_data_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    mem_addr_valid = 1'b0;
    #1;
    chk("init_ready", mem_addr_ready, 1'b1);
    chk("init_valid", mem_data_valid, 1'b0);

    // Reset mid-stream: reads of 5 and 6 are discarded.
    mem_addr_valid = 1'b1;
    mem_addr_data = 32'd5;
    tick();
    mem_addr_data = 32'd6;
    tick();
    rst_n = 1'b0;
    mem_addr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", mem_addr_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("post_reset_no_valid", mem_data_valid, 1'b0);
      tick();
    end

    // Single read: valid first high two cycles after the accept, one pulse.
    mem_addr_valid = 1'b1;
    mem_addr_data = 32'h10;
    mem_data_ready = 1'b1;
    tick();
    mem_addr_valid = 1'b0;
    chk("single_cyc1_valid", mem_data_valid, 1'b0);
    tick();
    e = model_resp(32'h10);
    chk("single_cyc2_valid", mem_data_valid, 1'b1);
    chk("single_data", mem_data, e[31:0]);
    tick();
    chk("single_cyc3_valid", mem_data_valid, 1'b0);

    // Streaming: 16 back-to-back accepts, 16 pops with no bubbles.
    a0 = n_acc;
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      mem_addr_valid = 1'b1;
      mem_addr_data = 32'(i);
      tick();
    end
    chk("stream_accepts", n_acc - a0, 16);
    drain("stream_drain");
    chk("stream_pops", pop_cyc.size(), 16);
    if (pop_cyc.size() >= 16) chk("stream_no_bubble", pop_cyc[15] - pop_cyc[0], 15);

    // Backpressure: only RESP_DEPTH accepts while the consumer stalls.
    a0 = n_acc;
    p0 = n_pop;
    idx = 0;
    mem_data_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_addr_valid = 1'b1;
      mem_addr_data = 32'h20 + 32'(idx);
      tick();
      if (last_acc) idx++;
    end
    chk("bp_accepts", n_acc - a0, RD);
    chk("bp_ready_low", mem_addr_ready, 1'b0);
    chk("bp_valid_high", mem_data_valid, 1'b1);
    mem_data_ready = 1'b1;
    for (int k = 0; k < 30 && (idx < 6 || exp_q.size() != 0); k++) begin
      mem_addr_valid = (idx < 6);
      mem_addr_data = 32'h20 + 32'(idx);
      tick();
      if (last_acc) idx++;
    end
    chk("bp_total_accepts", idx, 6);
    chk("bp_total_pops", n_pop - p0, 6);
    drain("bp_drain");

    // Full FIFO with ready toggling: push and pop coincide at full.
    a0 = n_acc;
    p0 = n_pop;
    idx = 0;
    mem_data_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_addr_valid = 1'b1;
      mem_addr_data = 32'h30 + 32'(idx);
      tick();
      if (last_acc) idx++;
    end
    chk("full_ready_low", mem_addr_ready, 1'b0);
    for (int k = 0; k < 40 && idx < 16; k++) begin
      mem_data_ready = (k % 2 == 0);
      mem_addr_valid = 1'b1;
      mem_addr_data = 32'h30 + 32'(idx);
      tick();
      if (last_acc) idx++;
    end
    chk("full_all_accepted", idx, 16);
    drain("full_drain");
    chk("full_pops_match", n_pop - p0, n_acc - a0);

`ifdef HANDSHAKE_LOAD_RESPONDER_BOUNDS_EN
    // Bounds: address 20 is out of range, address 3 is a normal read.
    mem_data_ready = 1'b1;
    mem_addr_valid = 1'b1;
    mem_addr_data = 32'd20;
    tick();
    mem_addr_data = 32'd3;
    tick();
    mem_addr_valid = 1'b0;
    chk("oob_head_valid", mem_data_valid, 1'b1);
    chk("oob_head_err", obs_err, 1'b1);
    chk("oob_head_data", mem_data, 32'h0);
    tick();
    chk("ib_err", obs_err, 1'b0);
    chk("ib_data", mem_data, 32'h1003_0303);
    drain("bounds_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
